// File: rtl/clb_config_loader_if.sv
// Signal bundle between the configuration pin side and clb_config_loader:
// the serial stream going in, and the CLB config-bus write port and status coming out.
interface clb_config_loader_if #(
  parameter int CFG_BITS = 37,
  parameter int ADDR_W   = 2
);
  logic                DIN;
  logic                DVALID;
  logic [CFG_BITS-1:0] CFG_DATA;
  logic [ADDR_W-1:0]   CFG_ADDR;
  logic                CFG_WE;
  logic                BUSY;
  logic                DONE;
  logic                ERR;

  // master: configuration pin side (drives the stream, observes the bus)
  modport master (
    output DIN, DVALID,
    input  CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
  );

  // slave: the loader itself
  modport slave (
    input  DIN, DVALID,
    output CFG_DATA, CFG_ADDR, CFG_WE, BUSY, DONE, ERR
  );
endinterface

// File: rtl/clb_config_loader.sv
// Serial configuration loader: hunts the 0010 preamble, reads an LSB-first frame count,
// then unpacks one start/data/stop frame per CLB into a one-cycle parallel write.
module clb_config_loader #(
  parameter int NUM_CLB  = 4,
  parameter int CFG_BITS = 37,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 2
) (
  input  logic               K,
  input  logic               RST,
  clb_config_loader_if.slave bus
);

  localparam int         BIT_MAX  = (CFG_BITS > CNT_W) ? CFG_BITS : CNT_W;
  localparam int         BCNT_W   = $clog2(BIT_MAX);
  localparam logic [3:0] PREAMBLE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_START,
    S_DATA,
    S_STOP,
    S_FINISH,  // last stop bit seen, waiting for its write strobe to go out
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          hist_q;        // three oldest bits of the preamble window
  logic [3:0]          window_nx;
  logic [CNT_W-1:0]    n_q, n_nx;
  logic [CNT_W-1:0]    idx_q, idx_inc;
  logic [BCNT_W-1:0]   bit_cnt_q;
  logic [CFG_BITS-1:0] sr_q;
  logic [CFG_BITS-1:0] cfg_data_q;
  logic [ADDR_W-1:0]   cfg_addr_q;
  logic                cfg_we_q;
  logic                wr_pend_q;
  logic                accept, lock, count_last, data_last, last_frame;
  logic                busy, done, err;

  assign accept     = bus.DVALID;
  assign window_nx  = {hist_q, bus.DIN};
  assign lock       = (window_nx == PREAMBLE);
  assign n_nx       = {bus.DIN, n_q[CNT_W-1:1]};
  assign count_last = (bit_cnt_q == BCNT_W'(CNT_W - 1));
  assign data_last  = (bit_cnt_q == BCNT_W'(CFG_BITS - 1));
  assign idx_inc    = idx_q + CNT_W'(1);
  assign last_frame = (idx_inc == n_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge K) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == S_FINISH) begin
      // The pending write does not wait for DVALID; DONE follows the strobe.
      if (cfg_we_q) state_d = S_DONE;
    end else if (accept) begin
      case (state_q)
        S_IDLE:  if (lock) state_d = S_COUNT;
        S_COUNT: begin
          if (count_last) begin
            if (n_nx == '0)                     state_d = S_DONE;
            else if (n_nx > CNT_W'(NUM_CLB))    state_d = S_ERR;
            else                                state_d = S_START;
          end
        end
        S_START: state_d = bus.DIN ? S_ERR : S_DATA;
        S_DATA:  if (data_last) state_d = S_STOP;
        S_STOP: begin
          if (!bus.DIN)        state_d = S_ERR;
          else if (last_frame) state_d = S_FINISH;
          else                 state_d = S_START;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (state_q)
      S_COUNT, S_START, S_DATA, S_STOP, S_FINISH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the frame shift register is reset along with everything else; it is
  // only a few dozen flops and keeps CFG_DATA free of X after any reset.
  always_ff @(posedge K) begin
    if (RST) begin
      hist_q     <= 3'b111;
      n_q        <= '0;
      idx_q      <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      cfg_data_q <= '0;
      cfg_addr_q <= '0;
      cfg_we_q   <= 1'b0;
      wr_pend_q  <= 1'b0;
    end else begin
      // A good stop bit arms wr_pend; the strobe goes out on the following edge.
      cfg_we_q  <= wr_pend_q;
      wr_pend_q <= 1'b0;
      if (wr_pend_q) begin
        cfg_data_q <= sr_q;
        cfg_addr_q <= idx_q[ADDR_W-1:0];
        idx_q      <= idx_inc;
      end

      if (accept) begin
        case (state_q)
          S_IDLE: begin
            hist_q <= window_nx[2:0];
            if (lock) begin
              n_q       <= '0;
              idx_q     <= '0;
              bit_cnt_q <= '0;
            end
          end
          S_COUNT: begin
            n_q       <= n_nx;
            bit_cnt_q <= count_last ? '0 : bit_cnt_q + BCNT_W'(1);
          end
          S_DATA: begin
            sr_q      <= {sr_q[CFG_BITS-2:0], bus.DIN};
            bit_cnt_q <= data_last ? '0 : bit_cnt_q + BCNT_W'(1);
          end
          S_STOP: if (bus.DIN) wr_pend_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.CFG_DATA = cfg_data_q;
  assign bus.CFG_ADDR = cfg_addr_q;
  assign bus.CFG_WE   = cfg_we_q;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.ERR      = err;

endmodule
